axis_split_sync: RTL and testbench
==================================

# axis_split_sync

Splits one concatenated AXI4-Stream word into two independently handshaken output streams, each with its own output register. Sits directly downstream of the two-channel stream combiner: it takes the `{channel1, channel0}` word and fans the halves back out to two consumers, such as per-channel FIFOs or DMA writers. It also keeps a beat counter and, optionally, an overflow counter for status readback.

## Interface
- `AXIS0_WIDTH`, default 16: width of the low field, which goes to m00.
- `AXIS1_WIDTH`, default 16: width of the high field, which goes to m01.
- `CNT_WIDTH`, default 32: width of `sts_count`.

- `aclk`  in  1  clock; all logic is rising-edge.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `s_axis_tdata`  in  AXIS0_WIDTH+AXIS1_WIDTH  input word; bits `[AXIS0_WIDTH-1:0]` go to m00, the upper bits go to m01.
- `s_axis_tvalid`  in  1  input valid.
- `s_axis_tready`  out  1  input ready.
- `m00_axis_tdata`  out  AXIS0_WIDTH  channel 0 data, registered.
- `m00_axis_tvalid`  out  1  channel 0 valid, registered.
- `m00_axis_tready`  in  1  channel 0 ready.
- `m01_axis_tdata`  out  AXIS1_WIDTH  channel 1 data, registered.
- `m01_axis_tvalid`  out  1  channel 1 valid, registered.
- `m01_axis_tready`  in  1  channel 1 ready.
- `sts_count`  out  CNT_WIDTH  number of input beats accepted; wraps modulo 2^CNT_WIDTH.
- `sts_overflow`  out  16  number of overwritten beats; saturates at 0xFFFF.

## Operation
- Two output slots, slot0 and slot1. Each holds a data register and a valid flag.
- Slot k is free when `!valid_k || mk_axis_tready`.
- Lossless mode, the default build: `s_axis_tready = free0 && free1`. This is combinational from the m readies and the registered valids.
- Accept means `s_axis_tvalid && s_axis_tready`. On accept:
  - both slots load their field;
  - both valid flags set;
  - `sts_count` increments.
- Without an accept, slot k clears its valid when `valid_k && mk_axis_tready`. Data registers hold their value.
- The two outputs drain independently. Channel 1 may complete its handshake cycles before or after channel 0.
- Every input beat is presented exactly once on each output, in order.
- `sts_count` wraps from all-ones to 0.

## Timing
- Reset values:
  - `m00_axis_tvalid = 0`, `m01_axis_tvalid = 0`;
  - `m00_axis_tdata = 0`, `m01_axis_tdata = 0`;
  - `sts_count = 0`, `sts_overflow = 0`;
  - `s_axis_tready = 1`, since both slots are empty (lossless mode).
- Latency: a beat accepted at edge N is valid on both outputs after edge N, i.e. one cycle.
- Throughput: one beat per cycle while both m readies are high.
- Simultaneous drain and load on the same edge: the load wins. Valid stays 1 and new data replaces the drained word.
- A stalled output holds its data and valid stable until its handshake completes (AXI rule).
- If one output is stalled, the input stalls. The other output completes its pending beat and then idles with valid low.
- Reset asserted mid-operation:
  - both valids clear immediately; pending data is discarded;
  - both counters clear;
  - the first post-reset beat appears normally.
- No combinational path from `s_axis_tvalid` to any output.

## Configuration
- Macro: `AXIS_SPLIT_SYNC_DROP_EN`.
- Defined, drop mode:
  - `s_axis_tready` is 1 whenever `aresetn` is high, so the input is never backpressured;
  - a beat arriving while a slot is occupied and not draining overwrites that slot;
  - `sts_overflow` increments by 1 per overwriting beat, even if both slots are overwritten, and saturates at 0xFFFF;
  - `sts_count` still counts every beat.
- Undefined: lossless mode as described above, and `sts_overflow` is tied to 0.

## Test plan
- Back-to-back flow: drive beats 0x0001_0000 through 0x0008_0007 with both readies high. Required: m00 shows 0x0000..0x0007, m01 shows 0x0001..0x0008, one beat per cycle, first output one cycle after the first accept, `sts_count = 8`.
- Skew: hold `m01_axis_tready = 0` for 5 cycles after beat 0xBEEF_CAFE. Required:
  - m00 completes 0xCAFE once, then valid goes low;
  - m01 holds 0xBEEF stable;
  - `s_axis_tready = 0` until m01 drains;
  - no beat lost or duplicated.
- Random readies: drive 1000 random beats with random independent readies and random input valid. Required: both output sequences match the scoreboard and `sts_count = 1000`.
- Reset mid-stream: assert `aresetn` low while both slots are valid. Required: valids go 0 asynchronously and counters read 0. After release, beat 0x1234_5678 emerges as 0x5678 / 0x1234.
- Counter wrap: set `CNT_WIDTH = 4` and drive 17 beats. Required: `sts_count = 1`.
- Drop mode (macro defined): hold `m00_axis_tready = 0` and drive 3 beats. Required: `s_axis_tready` stays 1, `sts_overflow = 2`, and m00 presents the third beat.

Source files
------------

// File: rtl/axis_split_sync.sv
// Splits one {channel1, channel0} AXI4-Stream word into two registered, independently drained outputs.
// Optional drop mode (never backpressures, counts overwrites) is enabled by `AXIS_SPLIT_SYNC_DROP_EN.
module axis_split_sync #(
   parameter int AXIS0_WIDTH = 16,
   parameter int AXIS1_WIDTH = 16,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                              aclk,
   input  logic                              aresetn,
   input  logic [AXIS0_WIDTH+AXIS1_WIDTH-1:0] s_axis_tdata,
   input  logic                              s_axis_tvalid,
   output logic                              s_axis_tready,
   output logic [AXIS0_WIDTH-1:0]            m00_axis_tdata,
   output logic                              m00_axis_tvalid,
   input  logic                              m00_axis_tready,
   output logic [AXIS1_WIDTH-1:0]            m01_axis_tdata,
   output logic                              m01_axis_tvalid,
   input  logic                              m01_axis_tready,
   output logic [CNT_WIDTH-1:0]              sts_count,
   output logic [15:0]                       sts_overflow
);

   logic                   valid0_reg, valid1_reg;
   logic [AXIS0_WIDTH-1:0] data0_reg;
   logic [AXIS1_WIDTH-1:0] data1_reg;
   logic [CNT_WIDTH-1:0]   count_reg;
   logic                   free0, free1, accept;

   assign free0 = !valid0_reg || m00_axis_tready;
   assign free1 = !valid1_reg || m01_axis_tready;

`ifdef AXIS_SPLIT_SYNC_DROP_EN
   logic [15:0] overflow_reg;
   logic        overwrite;

   // Input is never backpressured; a held slot is simply replaced.
   assign s_axis_tready = aresetn;
   assign overwrite     = accept && (!free0 || !free1);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         overflow_reg <= '0;
      end else if (overwrite && (overflow_reg != 16'hFFFF)) begin
         overflow_reg <= overflow_reg + 16'd1;
      end
   end

   assign sts_overflow = overflow_reg;
`else
   assign s_axis_tready = free0 && free1;
   assign sts_overflow  = 16'd0;
`endif

   assign accept = s_axis_tvalid && s_axis_tready;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         valid0_reg <= 1'b0;
         data0_reg  <= '0;
      end else if (accept) begin
         valid0_reg <= 1'b1;
         data0_reg  <= s_axis_tdata[AXIS0_WIDTH-1:0];
      end else if (m00_axis_tready) begin
         valid0_reg <= 1'b0;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         valid1_reg <= 1'b0;
         data1_reg  <= '0;
      end else if (accept) begin
         valid1_reg <= 1'b1;
         data1_reg  <= s_axis_tdata[AXIS0_WIDTH+AXIS1_WIDTH-1:AXIS0_WIDTH];
      end else if (m01_axis_tready) begin
         valid1_reg <= 1'b0;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         count_reg <= '0;
      end else if (accept) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign m00_axis_tdata  = data0_reg;
   assign m00_axis_tvalid = valid0_reg;
   assign m01_axis_tdata  = data1_reg;
   assign m01_axis_tvalid = valid1_reg;
   assign sts_count       = count_reg;

endmodule

// File: tb/tb_axis_split_sync.sv
// Randomized scoreboard bench for axis_split_sync; per-channel queues of pending words model the outputs.
// Also checks drop-mode behaviour when `AXIS_SPLIT_SYNC_DROP_EN is defined.
module tb_axis_split_sync;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [31:0] s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [15:0] m00_data, m01_data;
   logic        m00_valid, m01_valid;
   logic        m00_ready = 1'b0, m01_ready = 1'b0;
   logic [31:0] count;
   logic [15:0] overflow;

   logic        w_valid = 1'b0;
   logic        w_ready;
   logic [15:0] w_d0, w_d1;
   logic        w_v0, w_v1;
   logic [3:0]  w_count;
   logic [15:0] w_ovf;

   int          checks = 0;
   int          errors = 0;

   logic [15:0] q0[$];
   logic [15:0] q1[$];
   int unsigned exp_count = 0;
   int          exp_ovf = 0;

   always #5 aclk = ~aclk;

   axis_split_sync dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
      .m00_axis_tdata(m00_data), .m00_axis_tvalid(m00_valid), .m00_axis_tready(m00_ready),
      .m01_axis_tdata(m01_data), .m01_axis_tvalid(m01_valid), .m01_axis_tready(m01_ready),
      .sts_count(count), .sts_overflow(overflow)
   );

   axis_split_sync #(.CNT_WIDTH(4)) u_wrap (
      .aclk(aclk), .aresetn(aresetn),
      .s_axis_tdata(s_data), .s_axis_tvalid(w_valid), .s_axis_tready(w_ready),
      .m00_axis_tdata(w_d0), .m00_axis_tvalid(w_v0), .m00_axis_tready(1'b1),
      .m01_axis_tdata(w_d1), .m01_axis_tvalid(w_v1), .m01_axis_tready(1'b1),
      .sts_count(w_count), .sts_overflow(w_ovf)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      q0.delete();
      q1.delete();
      exp_count = 0;
      exp_ovf   = 0;
   endtask

   // One cycle: drive at the falling edge, check, advance the model, cross the rising edge.
   task automatic step(input logic r0, input logic r1, input logic sv, input logic [31:0] sd);
      logic mr, d0, d1, acc;
      m00_ready = r0;
      m01_ready = r1;
      s_valid   = sv;
      s_data    = sd;
      #1;
      check("m00_valid", m00_valid, q0.size() != 0);
      check("m01_valid", m01_valid, q1.size() != 0);
      if (q0.size() != 0) check("m00_data", m00_data, q0[0]);
      if (q1.size() != 0) check("m01_data", m01_data, q1[0]);
`ifdef AXIS_SPLIT_SYNC_DROP_EN
      mr = 1'b1;
`else
      mr = (q0.size() == 0 || r0) && (q1.size() == 0 || r1);
`endif
      check("s_ready", s_ready, mr);
      check("sts_count", count, exp_count);
      check("sts_overflow", overflow, exp_ovf);
      d0  = (q0.size() != 0) && r0;
      d1  = (q1.size() != 0) && r1;
      acc = sv && mr;
      if (d0) void'(q0.pop_front());
      if (d1) void'(q1.pop_front());
      if (acc) begin
         if (q0.size() != 0 || q1.size() != 0) begin
            if (exp_ovf < 16'hFFFF) exp_ovf++;
         end
         if (q0.size() != 0) q0[0] = sd[15:0]; else q0.push_back(sd[15:0]);
         if (q1.size() != 0) q1[0] = sd[31:16]; else q1.push_back(sd[31:16]);
         exp_count++;
      end
      @(posedge aclk);
      @(negedge aclk);
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      model_clear();
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
   endtask

   initial begin
      int cyc;
      do_reset();
      check("rst_m00_valid", m00_valid, 0);
      check("rst_m01_valid", m01_valid, 0);
      check("rst_m00_data", m00_data, 0);
      check("rst_m01_data", m01_data, 0);
      check("rst_count", count, 0);
      check("rst_overflow", overflow, 0);
      check("rst_s_ready", s_ready, 1);
      check("rst_wrap_count", w_count, 0);

      // Back-to-back beats 0x0001_0000 .. 0x0008_0007.
      for (int i = 0; i < 8; i++) begin
         logic [31:0] w;
         w = {16'(i + 1), 16'(i)};
         step(1'b1, 1'b1, 1'b1, w);
      end
      step(1'b1, 1'b1, 1'b0, 32'h0);
      check("b2b_count", count, 8);
      step(1'b1, 1'b1, 1'b0, 32'h0);

      // Skew: channel 1 stalled for five cycles.
      step(1'b1, 1'b1, 1'b1, 32'hBEEF_CAFE);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, $urandom);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

      // Reset asserted while both slots hold data.
      step(1'b0, 1'b0, 1'b1, 32'hAAAA_5555);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      #2;
      aresetn = 1'b0;
      #1;
      check("mid_rst_m00_valid", m00_valid, 0);
      check("mid_rst_m01_valid", m01_valid, 0);
      check("mid_rst_count", count, 0);
      check("mid_rst_overflow", overflow, 0);
`ifdef AXIS_SPLIT_SYNC_DROP_EN
      check("mid_rst_s_ready", s_ready, 0);
`else
      check("mid_rst_s_ready", s_ready, 1);
`endif
      model_clear();
      @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      step(1'b1, 1'b1, 1'b1, 32'h1234_5678);
      check("post_rst_m00", m00_data, 16'h5678);
      check("post_rst_m01", m01_data, 16'h1234);
      step(1'b1, 1'b1, 1'b0, 32'h0);

      // Random traffic: 1000 accepted beats with independent readies.
      do_reset();
      cyc = 0;
      while (exp_count < 1000 && cyc < 20000) begin
         logic [31:0] w;
         logic v;
         w = $urandom;
         v = ($urandom_range(0, 3) != 0);
         if (exp_count == 999) v = 1'b1;
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), v && (exp_count < 1000), w);
         cyc++;
      end
      check("random_within_budget", exp_count, 1000);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
      check("random_count", count, 1000);

`ifdef AXIS_SPLIT_SYNC_DROP_EN
      // Drop mode: channel 0 stalled, three beats; two overwrites.
      do_reset();
      step(1'b0, 1'b1, 1'b1, 32'h0011_0001);
      step(1'b0, 1'b1, 1'b1, 32'h0022_0002);
      step(1'b0, 1'b1, 1'b1, 32'h0033_0003);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      check("drop_overflow", overflow, 2);
      check("drop_m00_data", m00_data, 16'h0003);
      check("drop_s_ready", s_ready, 1);
      step(1'b1, 1'b1, 1'b0, 32'h0);
`endif

      // Counter wrap on the CNT_WIDTH = 4 instance: 17 beats leaves 1.
      do_reset();
      for (int i = 0; i < 17; i++) begin
         w_valid = 1'b1;
         s_data  = $urandom;
         @(negedge aclk);
      end
      w_valid = 1'b0;
      @(negedge aclk);
      check("wrap_count", w_count, 4'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
